// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared types and defaults for the I/D cache line-port arbiter
package arb_types;

  localparam int LINE_W_DEFAULT = 256;
  localparam int ADDR_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_grant_t;

  // Serving state that corresponds to a grant decision.
  function automatic arb_state_t grant_to_state(input arb_grant_t g);
    return (g == GNT_D) ? SERVE_D : SERVE_I;
  endfunction

endpackage

// File: rtl/cache_arbiter_priority_sel.sv
// rtl/cache_arbiter_priority_sel.sv - grant selection; ARB_RR_EN selects round-robin over fixed D-first
module arb_priority_sel
  import arb_types::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_grant_t last_grant,
  output arb_grant_t grant,
  output logic       valid
);

  // Pick the next cache to serve; only a tie is resolved differently between builds.
  always_comb begin
    valid = i_req | d_req;
`ifdef ARB_RR_EN
    if (i_req && d_req) begin
      grant = (last_grant == GNT_D) ? GNT_I : GNT_D;
    end else begin
      grant = d_req ? GNT_D : GNT_I;
    end
`else
    // The MEM-stage access is older than the fetch, so D wins a tie.
    grant = d_req ? GNT_D : GNT_I;
`endif
  end

`ifndef ARB_RR_EN
  // Fixed priority has no history; the port stays for a uniform interface.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - shares one pmem line port between I-cache and D-cache; ARB_RR_EN enables round-robin
module cache_arbiter
  import arb_types::*;
#(
  parameter int LINE_W = LINE_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state;
  arb_state_t state_next;
  arb_grant_t sel_grant;
  arb_grant_t last_grant;
  logic       sel_valid;
  logic       d_req;

  assign d_req = d_pmem_read | d_pmem_write;

  arb_priority_sel u_sel (
    .i_req      (i_pmem_read),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (sel_grant),
    .valid      (sel_valid)
  );

`ifdef ARB_RR_EN
  // Remember who was granted most recently so a tie goes to the other cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_I;
    end else if (state == IDLE && sel_valid) begin
      last_grant <= sel_grant;
    end
  end
`else
  assign last_grant = GNT_I;
`endif

  // Grant from IDLE; a grant is held until memory responds since it cannot abort.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_valid) state_next = grant_to_state(sel_grant);
      SERVE_I: if (pmem_resp) state_next = IDLE;
      SERVE_D: if (pmem_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any grant in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output steering is decoded from state only, so IDLE never passes a request through.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    i_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    case (state)
      SERVE_I: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        if (pmem_resp) begin
          i_pmem_resp  = 1'b1;
          i_pmem_rdata = pmem_rdata;
        end
      end
      SERVE_D: begin
        // Read and write together is illegal; the write takes precedence.
        pmem_write   = d_pmem_write;
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        if (pmem_resp) begin
          d_pmem_resp  = 1'b1;
          d_pmem_rdata = pmem_rdata;
        end
      end
      default: ;
    endcase
  end

  // Flag requester protocol violations in simulation; hardware keeps running.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(d_pmem_read && d_pmem_write))
        else $warning("cache_arbiter: d_pmem_read and d_pmem_write both high");
      assert (!(state == SERVE_I && !i_pmem_read))
        else $warning("cache_arbiter: I-cache dropped its request before resp");
      assert (!(state == SERVE_D && !d_req))
        else $warning("cache_arbiter: D-cache dropped its request before resp");
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter
module tb_cache_arbiter;
  import arb_types::*;

  localparam int LW = 256;
  localparam int AW = 32;
  localparam logic [LW-1:0] LINE_A = {8{32'h1234_5678}};
  localparam logic [LW-1:0] LINE_B = {8{32'hCAFE_F00D}};
  localparam logic [LW-1:0] LINE_C = {8{32'h0BAD_BEEF}};
  localparam logic [LW-1:0] LINE_5 = {32{8'hA5}};

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int checks = 0;
  int errors = 0;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = LINE_C; pmem_resp = 1'b1;
    tick; tick; #1;
    checks++;
    if (pmem_read !== 0 || pmem_write !== 0 || pmem_address !== 0 || pmem_wdata !== 0) begin
      errors++; $display("FAIL reset_pmem got r=%b w=%b a=%h exp 0", pmem_read, pmem_write, pmem_address);
    end
    checks++;
    if (i_pmem_resp !== 0 || d_pmem_resp !== 0 || i_pmem_rdata !== 0 || d_pmem_rdata !== 0) begin
      errors++; $display("FAIL reset_resp got i=%b d=%b exp 0", i_pmem_resp, d_pmem_resp);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++; $display("FAIL reset_state got %0d exp IDLE", dut.state);
    end
    pmem_resp = 1'b0;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_i_only;
    i_pmem_read = 1; i_pmem_address = 32'h0000_0060; #1;
    checks++;
    if (pmem_read !== 0) begin
      errors++; $display("FAIL i_only_idle_passthru got r=%b exp 0", pmem_read);
    end
    for (int c = 1; c <= 5; c++) begin
      tick;
      if (c == 5) begin pmem_resp = 1; pmem_rdata = LINE_A; end
      #1;
      checks++;
      if (pmem_read !== 1 || pmem_write !== 0 || pmem_address !== 32'h60) begin
        errors++; $display("FAIL i_only_strobe c=%0d got r=%b w=%b a=%h exp 1/0/60", c, pmem_read, pmem_write, pmem_address);
      end
      checks++;
      if (i_pmem_resp !== (c == 5) || d_pmem_resp !== 0) begin
        errors++; $display("FAIL i_only_resp c=%0d got i=%b d=%b exp %b/0", c, i_pmem_resp, d_pmem_resp, (c == 5));
      end
    end
    checks++;
    if (i_pmem_rdata !== LINE_A || d_pmem_rdata !== 0) begin
      errors++; $display("FAIL i_only_rdata got i=%h d=%h", i_pmem_rdata, d_pmem_rdata);
    end
    tick; pmem_resp = 0; i_pmem_read = 0; #1;
    checks++;
    if (pmem_read !== 0 || dut.state !== IDLE) begin
      errors++; $display("FAIL i_only_done got r=%b st=%0d exp 0/IDLE", pmem_read, dut.state);
    end
  endtask

  task automatic test_d_only;
    tick; d_pmem_read = 1; d_pmem_address = 32'h80;
    tick; #1;
    checks++;
    if (pmem_read !== 1 || pmem_write !== 0 || pmem_address !== 32'h80) begin
      errors++; $display("FAIL d_only_strobe got r=%b w=%b a=%h exp 1/0/80", pmem_read, pmem_write, pmem_address);
    end
    tick; pmem_resp = 1; pmem_rdata = LINE_B; #1;
    checks++;
    if (d_pmem_resp !== 1 || d_pmem_rdata !== LINE_B || i_pmem_resp !== 0 || i_pmem_rdata !== 0) begin
      errors++; $display("FAIL d_only_resp got d=%b i=%b drd=%h", d_pmem_resp, i_pmem_resp, d_pmem_rdata);
    end
    tick; pmem_resp = 0; d_pmem_read = 0;
  endtask

  task automatic test_simultaneous;
    bit first_d;
`ifdef ARB_RR_EN
    first_d = 0;
`else
    first_d = 1;
`endif
    tick;
    i_pmem_read = 1; i_pmem_address = 32'h100;
    d_pmem_write = 1; d_pmem_address = 32'h200; d_pmem_wdata = LINE_5;
    for (int t = 0; t < 2; t++) begin
      tick; #1;
      checks++;
      if (first_d) begin
        if (pmem_write !== 1 || pmem_read !== 0 || pmem_address !== 32'h200 || pmem_wdata !== LINE_5) begin
          errors++; $display("FAIL sim_d_serve t=%0d got r=%b w=%b a=%h", t, pmem_read, pmem_write, pmem_address);
        end
      end else begin
        if (pmem_read !== 1 || pmem_write !== 0 || pmem_address !== 32'h100 || pmem_wdata !== 0) begin
          errors++; $display("FAIL sim_i_serve t=%0d got r=%b w=%b a=%h", t, pmem_read, pmem_write, pmem_address);
        end
      end
      tick; pmem_resp = 1; pmem_rdata = LINE_A; #1;
      checks++;
      if (d_pmem_resp !== first_d || i_pmem_resp !== !first_d) begin
        errors++; $display("FAIL sim_resp t=%0d got d=%b i=%b exp d=%b", t, d_pmem_resp, i_pmem_resp, first_d);
      end
      tick; pmem_resp = 0;
      if (first_d) d_pmem_write = 0; else i_pmem_read = 0;
      #1;
      if (t == 0) begin
        checks++;
        if (pmem_read !== 0 || pmem_write !== 0) begin
          errors++; $display("FAIL sim_bubble got r=%b w=%b exp 0/0", pmem_read, pmem_write);
        end
      end
      first_d = !first_d;
    end
  endtask

  task automatic test_back_to_back;
    bit exp_d;
    bit got_d;
    bit seen;
    i_pmem_read = 1; i_pmem_address = 32'h300;
    d_pmem_read = 1; d_pmem_address = 32'h400;
    for (int k = 0; k < 8; k++) begin
      seen = 0;
      for (int w = 0; w < 8 && !seen; w++) begin
        tick; #1;
        if (pmem_read === 1) seen = 1;
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL b2b_timeout k=%0d got no strobe exp strobe", k);
        break;
      end
`ifdef ARB_RR_EN
      exp_d = (k % 2) == 1;
`else
      exp_d = 1;
`endif
      got_d = (pmem_address === 32'h400);
      if (got_d !== exp_d) begin
        errors++; $display("FAIL b2b_grant k=%0d got d=%b a=%h exp d=%b", k, got_d, pmem_address, exp_d);
      end
      pmem_resp = 1; pmem_rdata = LINE_C; #1;
      checks++;
      if (d_pmem_resp !== exp_d || i_pmem_resp !== !exp_d) begin
        errors++; $display("FAIL b2b_resp k=%0d got d=%b i=%b exp d=%b", k, d_pmem_resp, i_pmem_resp, exp_d);
      end
      tick; pmem_resp = 0; #1;
      checks++;
      if (pmem_read !== 0) begin
        errors++; $display("FAIL b2b_bubble k=%0d got r=%b exp 0", k, pmem_read);
      end
    end
    i_pmem_read = 0; d_pmem_read = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    d_pmem_write = 1; d_pmem_address = 32'h500; d_pmem_wdata = LINE_C;
    tick; #1;
    checks++;
    if (pmem_write !== 1 || dut.state !== SERVE_D) begin
      errors++; $display("FAIL rmid_serve got w=%b st=%0d exp 1/SERVE_D", pmem_write, dut.state);
    end
    rst = 1; d_pmem_write = 0;
    tick; rst = 0; #1;
    checks++;
    if (pmem_read !== 0 || pmem_write !== 0 || dut.state !== IDLE) begin
      errors++; $display("FAIL rmid_idle got r=%b w=%b st=%0d exp 0/0/IDLE", pmem_read, pmem_write, dut.state);
    end
    pmem_resp = 1; pmem_rdata = LINE_A; #1;
    checks++;
    if (d_pmem_resp !== 0 || i_pmem_resp !== 0 || d_pmem_rdata !== 0) begin
      errors++; $display("FAIL rmid_stray got d=%b i=%b exp 0/0", d_pmem_resp, i_pmem_resp);
    end
    tick; pmem_resp = 0; #1;
    checks++;
    if (dut.state !== IDLE) begin
      errors++; $display("FAIL rmid_state got %0d exp IDLE", dut.state);
    end
  endtask

  task automatic test_illegal;
    d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h600; d_pmem_wdata = LINE_B;
    tick; #1;
    checks++;
    if (pmem_write !== 1 || pmem_read !== 0 || pmem_address !== 32'h600 || pmem_wdata !== LINE_B) begin
      errors++; $display("FAIL illegal_write got r=%b w=%b a=%h exp 0/1/600", pmem_read, pmem_write, pmem_address);
    end
    tick; pmem_resp = 1; #1;
    checks++;
    if (d_pmem_resp !== 1 || i_pmem_resp !== 0) begin
      errors++; $display("FAIL illegal_resp got d=%b i=%b exp 1/0", d_pmem_resp, i_pmem_resp);
    end
    tick; pmem_resp = 0; d_pmem_read = 0; d_pmem_write = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_i_only;
    test_d_only;
    test_simultaneous;
    test_back_to_back;
    test_reset_mid;
    test_illegal;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
